// File: rtl/pb_operand_loader.sv
// Builds two 8-bit comparator operands from four debounced push buttons and a 4-bit switch bank.
// Each press captures the switches into one nibble; the full pair is then offered over valid/ready.
module pb_operand_loader #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic       pb4,
    input  logic [3:0] y,
    input  logic       out_ready,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       out_valid,
    output logic [3:0] loaded
);

    typedef enum logic {
        LOAD,
        VALID
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

    logic [3:0]  raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  db;
    logic [15:0] cnt [4];
    logic [3:0]  press;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_next;
    logic [7:0]  b_next;
    logic [3:0]  loaded_next;

    // Bit order matches the loaded flags: index 0 is pb1.
    assign raw = {pb4, pb3, pb2, pb1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // A press is the edge on which the debounced level flips from 0 to 1.
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST) && sync2[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            a      <= '0;
            b      <= '0;
            loaded <= '0;
        end else begin
            state  <= state_next;
            a      <= a_next;
            b      <= b_next;
            loaded <= loaded_next;
        end
    end

    always_comb begin
        state_next  = state;
        a_next      = a;
        b_next      = b;
        loaded_next = loaded;
        case (state)
            LOAD: begin
                if (loaded == 4'b1111) begin
                    state_next = VALID;
                end
                if (press[0]) a_next[7:4] = y;
                if (press[1]) a_next[3:0] = y;
                if (press[2]) b_next[7:4] = y;
                if (press[3]) b_next[3:0] = y;
                loaded_next = loaded | press;
            end
            VALID: begin
                // Operands stay frozen; presses seen here are dropped.
                if (out_ready) begin
                    state_next  = LOAD;
                    loaded_next = '0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign out_valid = (state == VALID);

endmodule

// File: tb/tb_pb_operand_loader.sv
// Directed bench for pb_operand_loader: press sequencing, bounce, overwrite, back-pressure and async reset.
module tb_pb_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       pb1, pb2, pb3, pb4;
    logic [3:0] y;
    logic       out_ready;
    logic [7:0] a, b;
    logic       out_valid;
    logic [3:0] loaded;

    int vectors;
    int miscompares;

    int         cap_tick;
    logic [3:0] cap_loaded;
    int         vld_tick;

    pb_operand_loader #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb1       (pb1),
        .pb2       (pb2),
        .pb3       (pb3),
        .pb4       (pb4),
        .y         (y),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .loaded    (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the buttons in mask for hold cycles, releases them, idles 8 cycles,
    // and reports the first tick where a/b/loaded changed and where out_valid rose.
    task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] yv, input int hold,
                                 output int ctick, output logic [3:0] cload, output int vtick);
        logic [19:0] prev;
        logic        prev_valid;
        ctick = 0;
        cload = '0;
        vtick = 0;
        y = yv;
        {pb4, pb3, pb2, pb1} = mask;
        for (int t = 1; t <= hold + 8; t++) begin
            if (t == hold + 1) {pb4, pb3, pb2, pb1} = 4'b0000;
            prev       = {a, b, loaded};
            prev_valid = out_valid;
            tick();
            if (ctick == 0 && {a, b, loaded} != prev) begin
                ctick = t;
                cload = loaded;
            end
            if (vtick == 0 && out_valid && !prev_valid) vtick = t;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        {pb4, pb3, pb2, pb1} = 4'b0000;
        y         = 4'h0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        tick();
        tick();
        checkOutput("reset_a", 16'(a), 16'h00);
        checkOutput("reset_b", 16'(b), 16'h00);
        checkOutput("reset_valid", 16'(out_valid), 16'h0);
        checkOutput("reset_loaded", 16'(loaded), 16'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic load of all four nibbles in turn.
        applyStimulus(4'b0001, 4'hD, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("seq1_latency", 16'(cap_tick), 16'd6);
        checkOutput("seq1_loaded", 16'(loaded), 16'b0001);
        checkOutput("seq1_a", 16'(a), 16'hD0);
        applyStimulus(4'b0010, 4'h0, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("seq2_latency", 16'(cap_tick), 16'd6);
        checkOutput("seq2_loaded", 16'(loaded), 16'b0011);
        applyStimulus(4'b0100, 4'hD, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("seq3_loaded", 16'(loaded), 16'b0111);
        checkOutput("seq3_b", 16'(b), 16'hD0);
        checkOutput("seq3_valid", 16'(out_valid), 16'h0);
        applyStimulus(4'b1000, 4'h0, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("seq4_loaded", 16'(cap_loaded), 16'b1111);
        checkOutput("seq4_valid_tick", 16'(vld_tick), 16'd7);
        checkOutput("seq4_valid_held", 16'(out_valid), 16'h1);
        checkOutput("seq4_a", 16'(a), 16'hD0);
        checkOutput("seq4_b", 16'(b), 16'hD0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("accept_valid", 16'(out_valid), 16'h0);
        checkOutput("accept_loaded", 16'(loaded), 16'h0);
        checkOutput("accept_a_kept", 16'(a), 16'hD0);

        // Bounce on pb2: 3 high, 1 low, then steady high.
        y = 4'h7;
        pb2 = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        pb2 = 1'b0;
        tick();
        pb2 = 1'b1;
        cap_tick = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (cap_tick == 0 && loaded != 4'b0000) begin
                cap_tick = t;
                y = 4'h0;
            end
        end
        checkOutput("bounce_latency", 16'(cap_tick), 16'd6);
        checkOutput("bounce_a", 16'(a), 16'hD7);
        checkOutput("bounce_loaded", 16'(loaded), 16'b0010);
        pb2 = 1'b0;
        for (int t = 0; t < 8; t++) tick();

        // Overwrite pb1, then simultaneous pb3+pb4.
        applyStimulus(4'b0001, 4'h3, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("ovw1_a", 16'(a), 16'h37);
        applyStimulus(4'b0001, 4'hA, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("ovw2_a", 16'(a), 16'hA7);
        checkOutput("ovw2_loaded", 16'(loaded), 16'b0011);
        applyStimulus(4'b1100, 4'h5, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("simul_b", 16'(b), 16'h55);
        checkOutput("simul_same_edge", 16'(cap_loaded), 16'b1111);
        checkOutput("simul_valid_tick", 16'(vld_tick), 16'd7);

        // Back-pressure: presses in VALID are discarded.
        applyStimulus(4'b0001, 4'hF, 8, cap_tick, cap_loaded, vld_tick);
        for (int t = 0; t < 4; t++) tick();
        checkOutput("bp_no_change", 16'(cap_tick), 16'd0);
        checkOutput("bp_a", 16'(a), 16'hA7);
        checkOutput("bp_valid", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_accept_valid", 16'(out_valid), 16'h0);
        checkOutput("bp_accept_loaded", 16'(loaded), 16'h0);
        checkOutput("bp_accept_a", 16'(a), 16'hA7);
        checkOutput("bp_accept_b", 16'(b), 16'h55);

        // Async reset with pb4 mid-debounce and three nibbles loaded.
        applyStimulus(4'b0001, 4'h1, 8, cap_tick, cap_loaded, vld_tick);
        applyStimulus(4'b0010, 4'h2, 8, cap_tick, cap_loaded, vld_tick);
        applyStimulus(4'b0100, 4'h3, 8, cap_tick, cap_loaded, vld_tick);
        checkOutput("pre_rst_loaded", 16'(loaded), 16'b0111);
        checkOutput("pre_rst_a", 16'(a), 16'h12);
        y   = 4'h9;
        pb4 = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_a", 16'(a), 16'h00);
        checkOutput("async_b", 16'(b), 16'h00);
        checkOutput("async_loaded", 16'(loaded), 16'h0);
        checkOutput("async_valid", 16'(out_valid), 16'h0);
        #2 rst_n = 1'b1;
        cap_tick = 0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (cap_tick == 0 && loaded != 4'b0000) cap_tick = t;
        end
        checkOutput("post_rst_latency", 16'(cap_tick), 16'd6);
        checkOutput("post_rst_loaded", 16'(loaded), 16'b1000);
        checkOutput("post_rst_b", 16'(b), 16'h09);
        checkOutput("post_rst_a", 16'(a), 16'h00);
        pb4 = 1'b0;
        for (int t = 0; t < 8; t++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
